// File: rtl/seg7_scan.sv
// Four-digit multiplexed common-anode hex display driver with per-frame snapshot and
// inter-digit blanking. Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan #(
    parameter int unsigned CLK_DIV   = 50000,
    parameter int unsigned BLANK_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  cathode,
    output logic        dp
);

    localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_digit;
    logic [15:0]      r_snap;
    logic [3:0]       r_snap_dp;
    logic [3:0]       r_an;
    logic [6:0]       r_cathode;
    logic             r_dp;

    logic             w_cnt_wrap;
    logic             w_frame_start;
    logic             w_blank;
    logic [3:0]       w_nibble;
    logic             w_dp_req;
    logic [3:0]       w_digit_sel;
    logic [3:0]       w_lead_zero;
    logic [3:0]       w_an_nxt;
    logic [6:0]       w_cathode_nxt;
    logic             w_dp_nxt;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign w_cnt_wrap    = (r_cnt == CNT_MAX);
    assign w_frame_start = (r_cnt == '0) && (r_digit == 2'd0);
    // With BLANK_CYC >= CLK_DIV this is always true, so the display stays dark.
    assign w_blank       = (32'(r_cnt) < BLANK_CYC);

    always_comb begin
        w_nibble    = r_snap[3:0];
        w_dp_req    = r_snap_dp[0];
        w_digit_sel = 4'b1110;
        unique case (r_digit)
            2'd0: begin
                w_nibble    = r_snap[3:0];
                w_dp_req    = r_snap_dp[0];
                w_digit_sel = 4'b1110;
            end
            2'd1: begin
                w_nibble    = r_snap[7:4];
                w_dp_req    = r_snap_dp[1];
                w_digit_sel = 4'b1101;
            end
            2'd2: begin
                w_nibble    = r_snap[11:8];
                w_dp_req    = r_snap_dp[2];
                w_digit_sel = 4'b1011;
            end
            2'd3: begin
                w_nibble    = r_snap[15:12];
                w_dp_req    = r_snap_dp[3];
                w_digit_sel = 4'b0111;
            end
        endcase
    end

`ifdef SEG7_LZB_EN
    // A digit is a leading zero when it and every higher digit are zero with no dp lit.
    always_comb begin
        w_lead_zero    = 4'b0000;
        w_lead_zero[3] = (r_snap[15:12] == 4'h0) && !r_snap_dp[3];
        w_lead_zero[2] = w_lead_zero[3] && (r_snap[11:8] == 4'h0) && !r_snap_dp[2];
        w_lead_zero[1] = w_lead_zero[2] && (r_snap[7:4] == 4'h0) && !r_snap_dp[1];
    end
`else
    assign w_lead_zero = 4'b0000;
`endif

    always_comb begin
        w_an_nxt      = 4'b1111;
        w_cathode_nxt = 7'b1111111;
        w_dp_nxt      = 1'b1;
        if (!w_blank) begin
            w_an_nxt      = w_digit_sel;
            w_cathode_nxt = w_lead_zero[r_digit] ? 7'b1111111 : hex_to_seg(w_nibble);
            w_dp_nxt      = ~w_dp_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_digit <= 2'd0;
        end else if (w_cnt_wrap) begin
            r_cnt   <= '0;
            r_digit <= r_digit + 2'd1;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap    <= 16'h0000;
            r_snap_dp <= 4'b0000;
        end else if (w_frame_start) begin
            r_snap    <= value;
            r_snap_dp <= dp_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an      <= 4'b1111;
            r_cathode <= 7'b1111111;
            r_dp      <= 1'b1;
        end else begin
            r_an      <= w_an_nxt;
            r_cathode <= w_cathode_nxt;
            r_dp      <= w_dp_nxt;
        end
    end

    assign an      = r_an;
    assign cathode = r_cathode;
    assign dp      = r_dp;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan (CLK_DIV=8, BLANK_CYC=2): stimulus pushes expected lit
// slots per frame, a negedge monitor pops and compares each lit slot.
module tb_seg7_scan;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  cathode;
    logic        dp;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];

    seg7_scan #(
        .CLK_DIV  (8),
        .BLANK_CYC(2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .value  (value),
        .dp_in  (dp_in),
        .an     (an),
        .cathode(cathode),
        .dp     (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;  4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;  4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;  4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;  4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;  4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Expected slots for one frame, digit 0 first; dp per digit is the inverse request.
    task automatic push_frame(input logic [3:0] d, input logic [6:0] c0, input logic [6:0] c1,
                              input logic [6:0] c2, input logic [6:0] c3);
        exp_q.push_back({4'b1110, c0, ~d[0]});
        exp_q.push_back({4'b1101, c1, ~d[1]});
        exp_q.push_back({4'b1011, c2, ~d[2]});
        exp_q.push_back({4'b0111, c3, ~d[3]});
    endtask

    // Called just after a negedge whose following posedge is a frame start.
    task automatic run_frame(input logic [15:0] v, input logic [3:0] d, input logic [6:0] c0,
                             input logic [6:0] c1, input logic [6:0] c2, input logic [6:0] c3);
        value = v;
        dp_in = d;
        push_frame(d, c0, c1, c2, c3);
        repeat (32) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic run_model_frame(input logic [15:0] v, input logic [3:0] d);
        logic [6:0] c[4];
        for (int i = 0; i < 4; i++) begin
            c[i] = seg_of(v[4*i +: 4]);
`ifdef SEG7_LZB_EN
            if (i > 0 && (v >> (4 * i)) == 16'h0 && (d >> i) == 4'h0) c[i] = 7'b1111111;
`endif
        end
        run_frame(v, d, c[0], c[1], c[2], c[3]);
    endtask

    // Monitor: every lit cycle is compared against the slot at the queue head.
    logic [11:0] cur;
    int          lit_cnt;
    int          blank_run;
    bit          seen_lit;
    bit          prev_lit;
    longint      cyc;
    longint      last_s0;

    initial begin
        cur = '0; lit_cnt = 0; blank_run = 0; seen_lit = 0; prev_lit = 0;
        cyc = 0; last_s0 = -1;
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            lit_cnt   = 0;
            blank_run = 0;
            seen_lit  = 0;
            prev_lit  = 0;
            last_s0   = -1;
        end else if (an == 4'b1111) begin
            if (prev_lit) check("lit_len", 32'(lit_cnt), 32'd0);
            check("blank_seg", {24'd0, cathode, dp}, {24'd0, 7'b1111111, 1'b1});
            blank_run++;
            prev_lit = 0;
        end else begin
            check("an_onehot", 32'($onehot(~an)), 32'd1);
            if (lit_cnt == 0) begin
                if (seen_lit) check("blank_len", 32'(blank_run), 32'd2);
                if (an == 4'b1110) begin
                    if (last_s0 >= 0) check("frame_period", 32'(cyc - last_s0), 32'd32);
                    last_s0 = cyc;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_lit", {20'd0, an, cathode, dp}, 32'hFFF);
                    cur = {an, cathode, dp};
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            check("slot_out", {20'd0, an, cathode, dp}, {20'd0, cur});
            lit_cnt = (lit_cnt == 5) ? 0 : lit_cnt + 1;
            seen_lit  = 1;
            prev_lit  = 1;
            blank_run = 0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        value = 16'h0000;
        dp_in = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset_an", {28'd0, an}, 32'hF);
        check("reset_cathode", {25'd0, cathode}, 32'h7F);
        check("reset_dp", {31'd0, dp}, 32'd1);
        #1;
        value = 16'h12AF;
        rst_n = 1'b1;

        // Plain frames, then a mid-frame change that must not tear.
        run_frame(16'h12AF, 4'b0000, 7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001);
        push_frame(4'b0000, 7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001);
        repeat (12) @(posedge clk);
        @(negedge clk);
        #1;
        value = 16'h3456;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        run_frame(16'h3456, 4'b0000, 7'b0000010, 7'b0010010, 7'b0011001, 7'b0110000);

        run_frame(16'h8888, 4'b0100, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000);

`ifdef SEG7_LZB_EN
        run_frame(16'h0007, 4'b0000, 7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111);
        run_frame(16'h0000, 4'b0000, 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);
        run_frame(16'h0000, 4'b0100, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1111111);
`else
        run_frame(16'h0007, 4'b0000, 7'b1111000, 7'b1000000, 7'b1000000, 7'b1000000);
        run_frame(16'h0000, 4'b0000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
        run_frame(16'h0000, 4'b0100, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
`endif

        // Reset mid-scan: outputs must go dark before the next clock edge.
        value = 16'h12AF;
        dp_in = 4'b0000;
        push_frame(4'b0000, 7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_an", {28'd0, an}, 32'hF);
        check("midrst_cathode", {25'd0, cathode}, 32'h7F);
        check("midrst_dp", {31'd0, dp}, 32'd1);
        exp_q.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(16'hC0DE, 4'b1001, 7'b0000110, 7'b0100001, 7'b1000000, 7'b1000110);

        for (int f = 0; f < 1000; f++) begin
            logic [15:0] v;
            logic [3:0]  d;
            v = 16'($urandom);
            d = 4'($urandom);
            if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
            if ($urandom_range(0, 3) == 0) d = 4'b0000;
            run_model_frame(v, d);
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
